csa_tree_pipe: RTL
==================

// Module: csa_tree_pipe
// PURPOSE
//  Parametrised, pipelined carry-save reduction tree for the multiplier datapath. It compresses NPP
//  partial products of width W into one redundant sum/carry pair, with sum + carry == SUM(pp) mod 2^W.
//  It replaces the per-column, purely combinational 13-input tree with a 3:2 reduction across the whole word.
//  Pipeline registers follow every LVL_PER_STAGE CSA levels, with valid/ready flow control.
//  It sits between the partial-product generator and the final carry-propagate adder.
// PARAMETERS
//  W              48  operand/result width in bits (>=2)
//  NPP            13  number of partial products (>=3)
//  LVL_PER_STAGE  2   3:2 CSA levels between pipeline registers (>=1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  flush      in   1      synchronous: invalidate all in-flight data
//  in_valid   in   1      pp bus holds a valid operand set
//  in_ready   out  1      tree accepts this cycle
//  pp         in   NPP*W  partial product k = pp[k*W +: W]
//  out_valid  out  1      sum/carry valid
//  out_ready  in   1      consumer accepts this cycle
//  sum        out  W      redundant sum vector
//  carry      out  W      redundant carry vector, already shifted left 1 (bit0=0, MSB carry dropped)
//  product    out  W      only with CSA_FINAL_ADD_EN: sum+carry mod 2^W
// BEHAVIOUR
//  - Levels L: the row count r starts at NPP and becomes r - floor(r/3) each level until r==2
//    (NPP=13: 13,9,6,4,3,2 -> L=5). Stages S = ceil(L/LVL_PER_STAGE) (default 3).
//  - Each level groups rows in triples from row 0 upward. Leftover rows (r mod 3) pass through unchanged.
//  - All adds are modulo 2^W. Carries out of bit W-1 are discarded. Operands are unsigned or two's complement.
//  - Pipeline: S register stages, each with a valid bit. A stage loads when it is empty or its contents move on.
//    in_ready = !flush && (stage1 empty || stage1 advancing). A transfer happens when in_valid && in_ready.
//  - Latency: a transfer in cycle t gives out_valid at t+S if out_ready is held high.
//    Throughput is 1 per cycle with no bubbles.
//  - Back-pressure: out_valid && !out_ready holds the final stage; sum/carry stay stable.
//    Upstream stages fill any empty slots, then in_ready falls. No data is lost or duplicated.
//  - in_ready is combinationally dependent on out_ready (ready chain). Datapath registers are not reset.
//  - flush: at the next edge all stage valids clear. An input offered in the same cycle is not accepted.
//    Flush has priority over load and over out_ready.
//  - Reset (any time, including mid-operation): all valids clear asynchronously.
//    out_valid=0, in_ready=1 from release, sum=carry=0 (final stage datapath is reset), product=0.
//  - Out-of-range parameters (NPP<3, W<2, LVL_PER_STAGE<1) are rejected at elaboration.
// CONFIGURATION
//  CSA_FINAL_ADD_EN defined:
//    - One extra register stage after the tree holds a full carry-propagate add into product.
//    - Latency is S+1. sum/carry are the same-cycle registered copies aligned with product.
//    - Handshake rules are unchanged.
//  Not defined: the product port is absent, latency is S, and no adder is built.
// TESTING
//  1 rst low mid-stream with 3 items in flight -> out_valid=0 at once, sum=carry=0; after release no stale output appears.
//  2 all 13 pp=48'h1, out_ready=1 -> 3 cycles later out_valid=1, sum+carry=48'hD.
//  3 all 13 pp=48'hFFFF_FFFF_FFFF -> sum+carry=48'hFFFF_FFFF_FFF3 (-13 mod 2^48), carry[0]=0.
//  4 stream 20 random sets, out_ready held low for cycles 5-9 -> in_ready low once stages fill.
//    All 20 results arrive in order, each matching the reference modulo sum.
//  5 flush with in_valid=1 and 2 items in flight -> next cycle all stages empty, no output for those 3 sets.
//  6 CSA_FINAL_ADD_EN, pp0=48'd1000, pp1=48'd234, rest 0 -> product=48'd1234 at latency 4.

Source files
------------

// File: rtl/csa_tree_pipe_if.sv
// Handshake bundle for csa_tree_pipe: operand side (flush/in_valid/in_ready/pp) and result side.
// CSA_FINAL_ADD_EN adds the product vector to the result side.
interface csa_tree_pipe_if #(
    parameter int W   = 48,
    parameter int NPP = 13
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [NPP*W-1:0] pp;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     sum;
    logic [W-1:0]     carry;
`ifdef CSA_FINAL_ADD_EN
    logic [W-1:0]     product;

    modport master (output flush, in_valid, pp, out_ready,
                    input  in_ready, out_valid, sum, carry, product);
    modport slave  (input  flush, in_valid, pp, out_ready,
                    output in_ready, out_valid, sum, carry, product);
`else
    modport master (output flush, in_valid, pp, out_ready,
                    input  in_ready, out_valid, sum, carry);
    modport slave  (input  flush, in_valid, pp, out_ready,
                    output in_ready, out_valid, sum, carry);
`endif
endinterface

// File: rtl/csa_tree_pipe.sv
// Pipelined word-wide 3:2 carry-save tree: NPP rows of W bits -> sum/carry with sum+carry == SUM(pp) mod 2^W.
// Optional CSA_FINAL_ADD_EN appends a register stage holding the carry-propagate result in product.
module csa_tree_pipe #(
    parameter int W             = 48,
    parameter int NPP           = 13,
    parameter int LVL_PER_STAGE = 2
) (
    input logic           clk,
    input logic           rst,
    csa_tree_pipe_if.slave bus
);

    function automatic int rows_at(input int l);
        int r;
        r = NPP;
        for (int k = 0; k < l; k++) r = r - r / 3;
        return r;
    endfunction

    function automatic int num_levels();
        int r;
        int n;
        r = NPP;
        n = 0;
        while (r > 2) begin
            r = r - r / 3;
            n++;
        end
        return n;
    endfunction

    function automatic int stage_end(input int s, input int nl, input int lps);
        int e;
        e = (s + 1) * lps;
        return (e > nl) ? nl : e;
    endfunction

    // Bit offset of level l's output rows inside the flat lv_out bus.
    function automatic int lout_off(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) o += rows_at(k + 1);
        return o * W;
    endfunction

    function automatic int st_off(input int s, input int nl, input int lps);
        int o;
        o = 0;
        for (int k = 0; k < s; k++) o += rows_at(stage_end(k, nl, lps));
        return o * W;
    endfunction

    localparam int L_RAW     = num_levels();
    localparam int L         = (L_RAW < 1) ? 1 : L_RAW;
    localparam int LPS       = (LVL_PER_STAGE < 1) ? 1 : LVL_PER_STAGE;
    localparam int S         = (L + LPS - 1) / LPS;
`ifdef CSA_FINAL_ADD_EN
    localparam int NS        = S + 1;
`else
    localparam int NS        = S;
`endif
    localparam int LOUT_BITS = lout_off(L);
    localparam int ST_BITS   = (S > 1) ? st_off(S - 1, L, LPS) : W;
    localparam int FO        = lout_off(L - 1);

    if (NPP < 3 || W < 2 || LVL_PER_STAGE < 1) begin : g_bad_param
        $error("csa_tree_pipe: need NPP>=3, W>=2, LVL_PER_STAGE>=1");
    end

    wire  [LOUT_BITS-1:0] lv_out;
    wire  [ST_BITS-1:0]   st_d;
    wire  [ST_BITS-1:0]   st_m;
    logic [ST_BITS-1:0]   st_q;
    logic [W-1:0]         fin_sum;
    logic [W-1:0]         fin_carry;

    logic [NS-1:0] v_q;
    logic [NS-1:0] rdy;
    logic [NS-1:0] ld;
    logic [NS:0]   vchain;

    // Each level: triples from row 0 become (sum, carry<<1) pairs; leftover rows follow unchanged.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int RI = rows_at(l);
        localparam int NT = RI / 3;
        localparam int NL = RI % 3;
        localparam int OO = lout_off(l);
        logic [RI*W-1:0] din;

        if (l == 0) begin : g_src_pp
            assign din = bus.pp;
        end else if (l % LPS == 0) begin : g_src_reg
            assign din = st_q[st_off(l / LPS - 1, L, LPS) +: RI*W];
        end else begin : g_src_comb
            assign din = lv_out[lout_off(l - 1) +: RI*W];
        end

        for (genvar t = 0; t < NT; t++) begin : g_csa
            logic [W-1:0] a, b, c;
            assign a = din[(3*t)*W +: W];
            assign b = din[(3*t+1)*W +: W];
            assign c = din[(3*t+2)*W +: W];
            assign lv_out[OO + (2*t)*W +: W]   = a ^ b ^ c;
            assign lv_out[OO + (2*t+1)*W +: W] = ((a & b) | (a & c) | (b & c)) << 1;
        end

        for (genvar k = 0; k < NL; k++) begin : g_pass
            assign lv_out[OO + (2*NT+k)*W +: W] = din[(3*NT+k)*W +: W];
        end
    end

    if (S > 1) begin : g_mid
        for (genvar s = 0; s < S - 1; s++) begin : g_stg
            localparam int N  = rows_at(stage_end(s, L, LPS)) * W;
            localparam int SO = st_off(s, L, LPS);
            assign st_d[SO +: N] = lv_out[lout_off(stage_end(s, L, LPS) - 1) +: N];
            assign st_m[SO +: N] = {N{ld[s]}};
        end
    end else begin : g_no_mid
        assign st_d = '0;
        assign st_m = '0;
    end

    always_ff @(posedge clk) begin
        st_q <= (st_d & st_m) | (st_q & ~st_m);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_sum   <= '0;
            fin_carry <= '0;
        end else if (ld[S-1]) begin
            fin_sum   <= lv_out[FO +: W];
            fin_carry <= lv_out[FO + W +: W];
        end
    end

    // valid/ready: stage s may take new contents when it is empty or every stage after it down to the
    // consumer can move (an empty slot anywhere downstream or out_ready); data loads only when upstream is valid.
    assign vchain = {v_q, bus.in_valid};

    always_comb begin
        logic acc;
        acc = bus.out_ready;
        rdy = '0;
        ld  = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            acc    = acc | ~v_q[s];
            rdy[s] = acc;
            ld[s]  = acc & vchain[s];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
        end else if (bus.flush) begin
            v_q <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (rdy[s]) v_q[s] <= vchain[s];
            end
        end
    end

    assign bus.in_ready  = ~bus.flush & rdy[0];
    assign bus.out_valid = vchain[NS];

`ifdef CSA_FINAL_ADD_EN
    logic [W-1:0] o_sum, o_carry, o_prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sum   <= '0;
            o_carry <= '0;
            o_prod  <= '0;
        end else if (ld[S]) begin
            o_sum   <= fin_sum;
            o_carry <= fin_carry;
            o_prod  <= fin_sum + fin_carry;
        end
    end

    assign bus.sum     = o_sum;
    assign bus.carry   = o_carry;
    assign bus.product = o_prod;
`else
    assign bus.sum   = fin_sum;
    assign bus.carry = fin_carry;
`endif

endmodule
